fib_datapath: RTL
=================

// Module: fib_datapath
// PURPOSE
//   Register file plus ALU that executes the per-cycle control word from the Fibonacci sequencing FSM.
//   It reads A = R[Rdest_sel] and B = (Imm_sel ? R[Rsrc_sel] : Imm_in), computes the result, and writes it to every register whose wEnable bit is set.
//   It returns Flags_out combinationally, so the FSM can branch in the same cycle it issues CMP.
//   R5 is exported as the sequence output for display logic.
// PARAMETERS
//   DATA_W    16   datapath/register width
//   NUM_REGS  16   register count; must equal width of wEnable
//   OUT_REG   5    index of register driven onto seq_out
// PORTS
//   clk        in   1        system clock, rising edge
//   reset_n    in   1        asynchronous, active-low reset
//   wEnable    in   16       one-hot/multi-hot register write enables
//   Imm_in     in   16       immediate operand (full width, no extension)
//   opcode     in   8        ALU operation select
//   Rdest_sel  in   4        A-operand register index
//   Rsrc_sel   in   4        B-operand register index (used when Imm_sel=1)
//   Imm_sel    in   1        1: B=R[Rsrc_sel]; 0: B=Imm_in
//   Flags_out  out  5        {L,N,Z,F,C} = [4]..[0]
//   alu_out    out  16       combinational ALU result
//   seq_out    out  16       registered copy of R[OUT_REG]
// BEHAVIOUR
//   Reset (async, reset_n=0): all registers = 0, flag register = 5'b0, so seq_out=0, Flags_out=0 (opcode NOP); held until reset_n rises.
//   Opcodes (other values are illegal):
//     00 NOP, result 0, no write
//     01 AND
//     02 OR
//     03 XOR
//     05 ADD
//     06 ADDU
//     60 ADDUI, A+B
//     09 SUB, A-B
//     0B CMP, A-B, NEVER writes even if wEnable!=0
//     0D MOV, result=B
//   Illegal opcode: alu_out=0, no register write, flags held.
//   Arithmetic: 17-bit internal sum; result truncated to DATA_W (wraps mod 2^16).
//   Flags, computed for ADD/ADDU/ADDUI/SUB/CMP only:
//     C: carry out of add; borrow (A<B unsigned) for SUB/CMP
//     F: signed overflow
//     Z: result==0
//     N: A<B signed
//     L: A<B unsigned
//   Flags_out mux: flag-updating op -> freshly computed flags (same-cycle bypass); any other op -> flag register.
//   Flag register: loads computed flags on clk edge when op is flag-updating; otherwise holds.
//   Write: on clk rising edge, R[k] <= alu_out for every k with wEnable[k]=1 and opcode is a legal writing op.
//     Multiple bits set: all selected registers get the same value.
//     Reads are pre-write, so an instruction reading and writing the same register (INC: R3=R3+1) sees the old value.
//   Latency: alu_out/Flags_out 0 cycles. A register write is visible to operands next cycle. seq_out follows a write to R[OUT_REG] one cycle later (registered mirror).
//   No forwarding is needed beyond this, since writes complete in one edge.
//   Reset mid-operation: pending write is discarded; state is as after power-up reset.
// CONFIGURATION
//   DP_DEBUG_PORT_EN defined:
//     adds ports dbg_sel in 4 and dbg_data out 16
//     dbg_data = R[dbg_sel], combinational, pre-write value, 0 during reset
//   Undefined: ports absent; no extra logic.
// TESTING
//   1. Reset: reset_n=0 mid-run after R1=7 -> all regs 0, Flags_out=0, seq_out=0 immediately (async).
//   2. ADDUI Rdest=1, Imm_sel=0, Imm_in=1, wEnable=0x0002 -> R1=1 next cycle; alu_out=1 same cycle.
//   3. CMP R3=3 vs R4=10, Imm_sel=1 -> Flags_out[4]=1, Z=0, no register changed. Repeat with R3=10 -> L=0, Z=1.
//   4. ADDU R0=0xFFFF + R1=0x0002, wEnable=0x0004 -> R2=0x0001, C=1, F=0. ADD 0x7FFF+1 -> F=1, result 0x8000.
//   5. wEnable=0x0022, MOV Imm=0x0055 -> R1=R5=0x0055; seq_out=0x0055 one cycle after the write.
//   6. Opcode 0xFF with wEnable=0xFFFF -> no writes, Flags_out equals prior flag register, alu_out=0.

Source files
------------

// File: rtl/fib_datapath_if.sv
// Control-word / result bundle between the Fibonacci sequencing FSM (master) and fib_datapath (slave).
// Purely structural: no storage and no handshake; the FSM issues one control word every cycle.
interface fib_datapath_if #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 16,
    parameter int IDX_W    = $clog2(NUM_REGS)
);
    logic [NUM_REGS-1:0] wEnable;
    logic [DATA_W-1:0]   Imm_in;
    logic [7:0]          opcode;
    logic [IDX_W-1:0]    Rdest_sel;
    logic [IDX_W-1:0]    Rsrc_sel;
    logic                Imm_sel;
    logic [4:0]          Flags_out;
    logic [DATA_W-1:0]   alu_out;
    logic [DATA_W-1:0]   seq_out;

    modport master (
        output wEnable, Imm_in, opcode, Rdest_sel, Rsrc_sel, Imm_sel,
        input  Flags_out, alu_out, seq_out
    );

    modport slave (
        input  wEnable, Imm_in, opcode, Rdest_sel, Rsrc_sel, Imm_sel,
        output Flags_out, alu_out, seq_out
    );
endinterface

// File: rtl/fib_datapath.sv
// Register file + ALU for the Fibonacci FSM; alu_out/Flags_out are 0-cycle, writes land on the next edge,
// seq_out mirrors R[OUT_REG] one edge later; no backpressure. DP_DEBUG_PORT_EN adds dbg_sel/dbg_data.
module fib_datapath #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 16,
    parameter int OUT_REG  = 5,
    parameter int IDX_W    = $clog2(NUM_REGS)
) (
    input  logic            clk,
    input  logic            reset_n,
    fib_datapath_if.slave   bus
`ifdef DP_DEBUG_PORT_EN
    ,
    input  logic [IDX_W-1:0]  dbg_sel,
    output logic [DATA_W-1:0] dbg_data
`endif
);

    localparam logic [7:0] OP_NOP   = 8'h00;
    localparam logic [7:0] OP_AND   = 8'h01;
    localparam logic [7:0] OP_OR    = 8'h02;
    localparam logic [7:0] OP_XOR   = 8'h03;
    localparam logic [7:0] OP_ADD   = 8'h05;
    localparam logic [7:0] OP_ADDU  = 8'h06;
    localparam logic [7:0] OP_ADDUI = 8'h60;
    localparam logic [7:0] OP_SUB   = 8'h09;
    localparam logic [7:0] OP_CMP   = 8'h0B;
    localparam logic [7:0] OP_MOV   = 8'h0D;

    localparam int MSB = DATA_W - 1;

    logic [DATA_W-1:0] r_regs [NUM_REGS];
    logic [4:0]        r_flags;
    logic [DATA_W-1:0] r_seq;

    logic [DATA_W-1:0] w_a;
    logic [DATA_W-1:0] w_b;
    logic [DATA_W:0]   w_sum;
    logic [DATA_W:0]   w_diff;
    logic              w_is_sub;
    logic [DATA_W-1:0] w_arith;
    logic              w_flag_c;
    logic              w_flag_f;
    logic              w_flag_z;
    logic              w_flag_n;
    logic              w_flag_l;
    logic [4:0]        w_flags;
    logic [DATA_W-1:0] w_result;
    logic              w_write;
    logic              w_flag_upd;

    // Operands are read from the pre-edge register state, so R3=R3+1 sees the old R3.
    assign w_a = r_regs[bus.Rdest_sel];
    assign w_b = bus.Imm_sel ? r_regs[bus.Rsrc_sel] : bus.Imm_in;

    assign w_sum  = {1'b0, w_a} + {1'b0, w_b};
    assign w_diff = {1'b0, w_a} - {1'b0, w_b};

    assign w_is_sub = (bus.opcode == OP_SUB) || (bus.opcode == OP_CMP);
    assign w_arith  = w_is_sub ? w_diff[MSB:0] : w_sum[MSB:0];

    // Carry for adds, borrow for subtracts; bit DATA_W of the difference is exactly A<B unsigned.
    assign w_flag_c = w_is_sub ? w_diff[DATA_W] : w_sum[DATA_W];
    assign w_flag_f = w_is_sub ? ((w_a[MSB] != w_b[MSB]) && (w_arith[MSB] != w_a[MSB]))
                               : ((w_a[MSB] == w_b[MSB]) && (w_arith[MSB] != w_a[MSB]));
    assign w_flag_z = (w_arith == '0);
    assign w_flag_n = ($signed(w_a) < $signed(w_b));
    assign w_flag_l = (w_a < w_b);
    assign w_flags  = {w_flag_l, w_flag_n, w_flag_z, w_flag_f, w_flag_c};

    always_comb begin
        w_result   = '0;
        w_write    = 1'b0;
        w_flag_upd = 1'b0;
        case (bus.opcode)
            OP_NOP: begin
                w_result = '0;
            end
            OP_AND: begin
                w_result = w_a & w_b;
                w_write  = 1'b1;
            end
            OP_OR: begin
                w_result = w_a | w_b;
                w_write  = 1'b1;
            end
            OP_XOR: begin
                w_result = w_a ^ w_b;
                w_write  = 1'b1;
            end
            OP_ADD, OP_ADDU, OP_ADDUI: begin
                w_result   = w_sum[MSB:0];
                w_write    = 1'b1;
                w_flag_upd = 1'b1;
            end
            OP_SUB: begin
                w_result   = w_diff[MSB:0];
                w_write    = 1'b1;
                w_flag_upd = 1'b1;
            end
            OP_CMP: begin
                w_result   = w_diff[MSB:0];
                w_flag_upd = 1'b1;
            end
            OP_MOV: begin
                w_result = w_b;
                w_write  = 1'b1;
            end
            default: begin
                w_result = '0;
            end
        endcase
    end

    // Fresh flags are bypassed so the FSM can branch in the same cycle it issues CMP.
    assign bus.Flags_out = w_flag_upd ? w_flags : r_flags;
    assign bus.alu_out   = w_result;
    assign bus.seq_out   = r_seq;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                r_regs[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_REGS; k++) begin
                if (w_write && bus.wEnable[k]) begin
                    r_regs[k] <= w_result;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_flags <= '0;
            r_seq   <= '0;
        end else begin
            if (w_flag_upd) begin
                r_flags <= w_flags;
            end
            r_seq <= r_regs[OUT_REG];
        end
    end

`ifdef DP_DEBUG_PORT_EN
    assign dbg_data = r_regs[dbg_sel];
`endif

endmodule
